cpu_power_ctrl: RTL and testbench
=================================

# cpu_power_ctrl

Run/halt/sleep state controller for the E0C6S46-style CPU core. It sits between instruction decode and the core's step enable. It parks the core on HALT and SLP, and gates the timer clock enable in sleep. It releases the core on a masked interrupt, inserting a configurable oscillator-restart delay after sleep. It generalises the fixed HALT/SLP "change nothing" behaviour to a parametrised number of interrupt sources, with a separate sleep-wake source mask.

## Interface
Parameters:
- NUM_INTERRUPTS, 6, number of interrupt sources.
- SLEEP_WAKE_MASK, 6'b000011, per-source bit; 1 = source may wake from SLEEP (all sources may wake from HALT).
- OSC_STARTUP_CYCLES, 4, clk_en ticks spent in WAKING after SLEEP release; 0 = none.
- STARTUP_WIDTH, 4, width of startup counter; must hold OSC_STARTUP_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  CPU tick enable (one instruction cycle step).
- halt_req  in  1  decode of HALT, sampled only in RUN with clk_en.
- sleep_req  in  1  decode of SLP, sampled only in RUN with clk_en.
- irq_pending  in  NUM_INTERRUPTS  raw interrupt factor flags.
- irq_mask  in  NUM_INTERRUPTS  interrupt mask register; 1 = enabled.
- cpu_run  out  1  core may execute; registered.
- timer_clk_en  out  1  clk_en qualified for timers; low in SLEEP and WAKING.
- state  out  2  RUN=0, HALT=1, SLEEP=2, WAKING=3.
- wake  out  1  one-clk pulse on return to RUN.
- halted_cycles  out  32  statistics; see Configuration.

## Operation
- wake_any = |(irq_pending & irq_mask). wake_sleep = |(irq_pending & irq_mask & SLEEP_WAKE_MASK).
- The I flag is not an input: HALT/SLEEP release is independent of the I flag, per the CPU manual.
- RUN:
  - clk_en & sleep_req -> SLEEP.
  - Else clk_en & halt_req -> HALT.
  - sleep_req has priority when both are asserted.
  - If the wake condition for the target state is already true in the request cycle, stay in RUN. No wake pulse is emitted, and the instruction acts as a NOP.
- HALT:
  - wake_any sampled every clk, not gated by clk_en.
  - wake_any -> RUN, wake=1.
- SLEEP:
  - wake_sleep sampled every clk -> WAKING, with the counter loaded with OSC_STARTUP_CYCLES.
  - If OSC_STARTUP_CYCLES==0, go directly to RUN with wake=1.
  - Non-sleep-wake sources are ignored.
- WAKING:
  - Counter decrements on clk_en.
  - A clk_en while the counter==1 -> RUN, wake=1.
  - Interrupts are ignored in this state.
- cpu_run=1 exactly when next state is RUN (registered alongside state).
- timer_clk_en = clk_en & (state==RUN || state==HALT); combinational from registered state.
- Reset values:
  - state=RUN, cpu_run=1, wake=0, counter=0, halted_cycles=0.
  - timer_clk_en follows clk_en.
- Reset in any state, including mid-WAKING, returns to RUN on the next edge. No wake pulse is emitted.
- Requests arriving while not in RUN are ignored.

## Timing
- HALT/SLP request with clk_en at edge N -> state/cpu_run update at N+1 (1 clk latency).
- HALT release: wake_any high before edge M -> state=RUN, cpu_run=1, wake=1 after M; wake drops after M+1.
- SLEEP release with OSC_STARTUP_CYCLES=K>0: WAKING after edge M, then RUN on the edge of the K-th subsequent clk_en.
- Total release latency is 1 clk + K clk_en ticks.
- Counter never underflows; WAKING with clk_en held low stays in WAKING indefinitely.
- Back-to-back: a HALT request may be accepted in the first RUN clk_en cycle after wake.

## Configuration
- CPU_POWER_CTRL_STATS_EN defined:
  - halted_cycles counts clk_en ticks where state != RUN.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- CPU_POWER_CTRL_STATS_EN undefined:
  - halted_cycles is tied to 0 and no counter logic is generated.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then halt_req with clk_en, irq_pending=0 -> state=1 and cpu_run=0 one clk later. Then set irq_pending=6'b000100, irq_mask=6'b000100 -> state=0, cpu_run=1, single-clk wake pulse.
- halt_req and sleep_req together -> state=2 and timer_clk_en=0. Then irq on source 2 (not in SLEEP_WAKE_MASK) -> stays 2. Then source 0 -> state=3, and RUN after exactly 4 clk_en ticks with wake=1.
- halt_req with irq_pending=irq_mask=6'b000001 already set -> state stays 0, wake never asserts.
- In WAKING after 2 clk_en ticks, assert reset -> state=0, cpu_run=1, wake=0.
- With CPU_POWER_CTRL_STATS_EN: HALT held for 10 clk_en ticks then released -> halted_cycles=10. Without the macro -> halted_cycles=0.
- OSC_STARTUP_CYCLES=0 build: SLEEP released by source 1 -> state=0 one clk after the irq, WAKING never observed.

Source files
------------

// File: rtl/cpu_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_power_ctrl
//  Purpose  : Run/halt/sleep state controller for an E0C6S46-style CPU core.
//             Parks the core on HALT/SLP, gates the timer tick enable while
//             asleep, and releases the core on a masked interrupt. Leaving
//             SLEEP can insert an oscillator-restart delay of
//             OSC_STARTUP_CYCLES clk_en ticks (the WAKING state).
//  Ports    : clk, reset (sync, active-high), clk_en (instruction tick),
//             halt_req / sleep_req (decode strobes, honoured only in RUN),
//             irq_pending / irq_mask (interrupt factor flags and enables),
//             cpu_run, timer_clk_en, state, wake (one-clk release pulse),
//             halted_cycles (statistics).
//  Options  : define CPU_POWER_CTRL_STATS_EN to build the saturating
//             halted_cycles counter; otherwise halted_cycles reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_power_ctrl #(
  parameter int                          NUM_INTERRUPTS     = 6,
  parameter logic [NUM_INTERRUPTS-1:0]   SLEEP_WAKE_MASK    = 6'b000011,
  parameter int                          OSC_STARTUP_CYCLES = 4,
  parameter int                          STARTUP_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      halt_req,
  input  logic                      sleep_req,
  input  logic [NUM_INTERRUPTS-1:0] irq_pending,
  input  logic [NUM_INTERRUPTS-1:0] irq_mask,
  output logic                      cpu_run,
  output logic                      timer_clk_en,
  output logic [1:0]                state,
  output logic                      wake,
  output logic [31:0]               halted_cycles
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKING = 2'd3
  } state_t;

  localparam logic [STARTUP_WIDTH-1:0] STARTUP_LOAD = STARTUP_WIDTH'(OSC_STARTUP_CYCLES);

  state_t                   state_q, state_d;
  logic                     cpu_run_q;
  logic                     wake_q, wake_d;
  logic [STARTUP_WIDTH-1:0] cnt_q, cnt_d;
  logic                     wake_any;
  logic                     wake_sleep;

  // HALT/SLEEP release ignores the CPU I flag; only the mask register counts.
  assign wake_any   = |(irq_pending & irq_mask);
  assign wake_sleep = |(irq_pending & irq_mask & SLEEP_WAKE_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cpu_run_q <= 1'b1;
      wake_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_run_q <= (state_d == ST_RUN);
      wake_q    <= wake_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wake_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // A request whose release condition is already met acts as a NOP.
        if (clk_en && sleep_req) begin
          if (!wake_sleep) state_d = ST_SLEEP;
        end else if (clk_en && halt_req) begin
          if (!wake_any) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (wake_any) begin
          state_d = ST_RUN;
          wake_d  = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (wake_sleep) begin
          if (OSC_STARTUP_CYCLES == 0) begin
            state_d = ST_RUN;
            wake_d  = 1'b1;
          end else begin
            state_d = ST_WAKING;
            cnt_d   = STARTUP_LOAD;
          end
        end
      end
      ST_WAKING: begin
        // Release on the tick that sees 1; the <= also stops any underflow.
        if (clk_en) begin
          if (cnt_q <= STARTUP_WIDTH'(1)) begin
            state_d = ST_RUN;
            wake_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - STARTUP_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign cpu_run      = cpu_run_q;
  assign state        = state_q;
  assign wake         = wake_q;
  assign timer_clk_en = clk_en && ((state_q == ST_RUN) || (state_q == ST_HALT));

`ifdef CPU_POWER_CTRL_STATS_EN
  logic [31:0] halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= '0;
    end else if (clk_en && (state_q != ST_RUN) && (halted_q != 32'hFFFF_FFFF)) begin
      halted_q <= halted_q + 32'd1;
    end
  end

  assign halted_cycles = halted_q;
`else
  assign halted_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_power_ctrl
//  Purpose  : Directed self-checking bench for cpu_power_ctrl. A second
//             instance built with OSC_STARTUP_CYCLES=0 covers the direct
//             SLEEP->RUN release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_power_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        halt_req;
  logic        sleep_req;
  logic [5:0]  irq_pending;
  logic [5:0]  irq_mask;

  logic        cpu_run, timer_clk_en, wake;
  logic [1:0]  state;
  logic [31:0] halted_cycles;

  logic        cpu_run0, timer_clk_en0, wake0;
  logic [1:0]  state0;
  logic [31:0] halted_cycles0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CPU_POWER_CTRL_STATS_EN
  localparam logic [31:0] EXP_HALTED = 32'd10;
`else
  localparam logic [31:0] EXP_HALTED = 32'd0;
`endif

  always #5 clk = ~clk;

  cpu_power_ctrl dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .halt_req(halt_req), .sleep_req(sleep_req),
    .irq_pending(irq_pending), .irq_mask(irq_mask),
    .cpu_run(cpu_run), .timer_clk_en(timer_clk_en), .state(state),
    .wake(wake), .halted_cycles(halted_cycles)
  );

  cpu_power_ctrl #(.OSC_STARTUP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .halt_req(halt_req), .sleep_req(sleep_req),
    .irq_pending(irq_pending), .irq_mask(irq_mask),
    .cpu_run(cpu_run0), .timer_clk_en(timer_clk_en0), .state(state0),
    .wake(wake0), .halted_cycles(halted_cycles0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; halt_req = 1'b0; sleep_req = 1'b0;
    irq_pending = '0; irq_mask = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_state",  32'(state), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd1);
    check("rst_wake",   32'(wake), 32'd0);
    check("rst_halted", halted_cycles, 32'd0);
    check("rst_tclk",   32'(timer_clk_en), 32'd1);

    // HALT entry, ignored sleep request, release by masked source 2
    halt_req = 1'b1;
    tick();                                  // E1: enter HALT
    halt_req = 1'b0;
    check("halt_state",   32'(state), 32'd1);
    check("halt_cpu_run", 32'(cpu_run), 32'd0);
    check("halt_tclk",    32'(timer_clk_en), 32'd1);
    sleep_req = 1'b1;
    tick();                                  // E2
    sleep_req = 1'b0;
    check("halt_ign_slp", 32'(state), 32'd1);
    for (int i = 0; i < 8; i++) tick();      // E3..E10
    check("halt_hold", 32'(state), 32'd1);
    irq_pending = 6'b000100; irq_mask = 6'b000100;
    tick();                                  // E11: release, 10th halted tick
    check("hrel_state",   32'(state), 32'd0);
    check("hrel_cpu_run", 32'(cpu_run), 32'd1);
    check("hrel_wake",    32'(wake), 32'd1);
    check("hrel_halted",  halted_cycles, EXP_HALTED);
    irq_pending = '0;
    tick();
    check("hrel_wake_drop", 32'(wake), 32'd0);
    check("hrel_halted2",   halted_cycles, EXP_HALTED);

    // SLEEP has priority; non-wake source ignored; 4-tick startup
    irq_mask = 6'b000111;
    halt_req = 1'b1; sleep_req = 1'b1;
    tick();
    halt_req = 1'b0; sleep_req = 1'b0;
    check("slp_state", 32'(state), 32'd2);
    check("slp_tclk",  32'(timer_clk_en), 32'd0);
    clk_en = 1'b0;
    irq_pending = 6'b000100;
    tick(); tick();
    check("slp_ign_src2", 32'(state), 32'd2);
    irq_pending = 6'b000001;
    tick();
    irq_pending = '0;
    check("wkg_state",   32'(state), 32'd3);
    check("wkg_cpu_run", 32'(cpu_run), 32'd0);
    tick();
    check("wkg_hold_noen", 32'(state), 32'd3);
    clk_en = 1'b1;
    check("wkg_tclk", 32'(timer_clk_en), 32'd0);
    tick(); tick(); tick();
    check("wkg_after3", 32'(state), 32'd3);
    check("wkg_wake3",  32'(wake), 32'd0);
    tick();
    check("wkrel_state",   32'(state), 32'd0);
    check("wkrel_wake",    32'(wake), 32'd1);
    check("wkrel_cpu_run", 32'(cpu_run), 32'd1);
    tick();
    check("wkrel_wake_drop", 32'(wake), 32'd0);

    // HALT with wake condition already true acts as a NOP
    irq_pending = 6'b000001; irq_mask = 6'b000001;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("nop_state", 32'(state), 32'd0);
    check("nop_wake",  32'(wake), 32'd0);
    tick();
    check("nop_wake2", 32'(wake), 32'd0);
    irq_pending = '0;

    // Reset in the middle of WAKING
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    check("rw_sleep", 32'(state), 32'd2);
    clk_en = 1'b0;
    irq_pending = 6'b000001;
    tick();
    irq_pending = '0;
    check("rw_waking", 32'(state), 32'd3);
    clk_en = 1'b1;
    tick(); tick();
    check("rw_waking2", 32'(state), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_state",   32'(state), 32'd0);
    check("rw_cpu_run", 32'(cpu_run), 32'd1);
    check("rw_wake",    32'(wake), 32'd0);

    // Zero-startup build: SLEEP -> RUN directly on source 1
    irq_mask = 6'b000010;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    check("z_sleep", 32'(state0), 32'd2);
    irq_pending = 6'b000010;
    tick();
    irq_pending = '0;
    check("z_state",   32'(state0), 32'd0);
    check("z_wake",    32'(wake0), 32'd1);
    check("z_cpu_run", 32'(cpu_run0), 32'd1);
    tick();
    check("z_wake_drop", 32'(wake0), 32'd0);
    check("z_state2",    32'(state0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
